// File: rtl/dm_wb_cache.sv
// dm_wb_cache: direct-mapped, write-back, write-allocate cache between the cpu word port and 256-bit line memory
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   mem_read/mem_write         cpu request, held until mem_resp (both set = write)
//   mem_byte_enable            write byte lanes
//   mem_address/mem_wdata      cpu byte address and write data
//   mem_rdata/mem_resp         read data and one-cycle completion pulse
//   pmem_read/pmem_write       line fill / victim writeback requests
//   pmem_address               line-aligned memory address
//   pmem_wdata/pmem_rdata      victim line out / fill line in
//   pmem_resp                  memory completion pulse
module dm_wb_cache #(
  parameter int s_index = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_wdata,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);
  localparam int sets = 1 << s_index;
  localparam int tw = 27 - s_index;
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, RESP} state_t;
  state_t state_q, state_d;
  logic [sets-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [tw-1:0] tag_q [sets];
  logic [tw-1:0] tag_d [sets];
  logic [255:0] data_q [sets];
  logic [255:0] data_d [sets];
  logic [31:0] rdata_q, rdata_d;
  logic [s_index-1:0] idx;
  logic [tw-1:0] atag;
  logic [2:0] ws;
  logic req, hit, unused_addr;
  assign idx = mem_address[4+s_index:5];
  assign atag = mem_address[31:5+s_index];
  assign ws = mem_address[4:2];
  assign unused_addr = ^mem_address[1:0];
  assign req = mem_read | mem_write;
  assign hit = valid_q[idx] & (tag_q[idx] == atag);
  assign mem_rdata = rdata_q;
  assign mem_resp = state_q == RESP;
  assign pmem_read = state_q == ALLOCATE;
  assign pmem_write = state_q == WRITEBACK;
  assign pmem_address = state_q == WRITEBACK ? {tag_q[idx], idx, 5'b0} :
                        state_q == ALLOCATE  ? {atag, idx, 5'b0} : 32'b0;
  assign pmem_wdata = data_q[idx];
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d = tag_q;
    data_d = data_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: if (req) begin
        if (hit) begin
          state_d = RESP;
          if (mem_write) begin
            for (int i = 0; i < 4; i++)
              if (mem_byte_enable[i]) data_d[idx][32*ws + 8*i +: 8] = mem_wdata[8*i +: 8];
            dirty_d[idx] = 1'b1;
          end else rdata_d = data_q[idx][32*ws +: 32];
        end else state_d = (valid_q[idx] & dirty_q[idx]) ? WRITEBACK : ALLOCATE;
      end
      // a request dropped during writeback skips the fill and returns to IDLE
      WRITEBACK: if (pmem_resp) begin
        dirty_d[idx] = 1'b0;
        state_d = req ? ALLOCATE : IDLE;
      end
      ALLOCATE: if (pmem_resp) begin
        data_d[idx] = pmem_rdata;
        tag_d[idx] = atag;
        valid_d[idx] = 1'b1;
        dirty_d[idx] = 1'b0;
        state_d = IDLE;
      end
      RESP: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      rdata_q <= rdata_d;
    end
  end
  // tag and data contents are meaningless until valid, so they carry no reset
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    data_q <= data_d;
  end
endmodule
